// File: rtl/input_conditioner_if.sv
// Pin-side and PIO-side signal bundle of the input conditioner.
// The slave modport belongs to the conditioner; the master modport belongs to whatever drives the pins.
interface input_conditioner_if #(
    parameter int N_PUSH = 4,
    parameter int N_SW   = 10
);
    logic [N_PUSH-1:0] key_n_in;
    logic [N_SW-1:0]   sw_in;
    logic [N_PUSH-1:0] push_out;
    logic [N_SW-1:0]   sw_out;
    logic [N_PUSH-1:0] push_press;
    logic [N_PUSH-1:0] push_release;

    modport master (
        output key_n_in, sw_in,
        input  push_out, sw_out, push_press, push_release
    );

    modport slave (
        input  key_n_in, sw_in,
        output push_out, sw_out, push_press, push_release
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces push-buttons and slide switches, one independent channel per bit,
// and emits one-cycle press/release pulses for the button channels.
module input_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int N_PUSH    = 4,
    parameter int N_SW      = 10
) (
    input logic               clk,
    input logic               reset_n,
    input_conditioner_if.slave io
);
    localparam int N  = N_PUSH + N_SW;
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    // Button pins are active-low; this mask both idles their synchronisers and inverts them.
    localparam logic [N-1:0]  INV     = {{N_SW{1'b0}}, {N_PUSH{1'b1}}};
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [N-1:0]      s1, s2, st, st_nxt, accept, d;
    logic [CW-1:0]     cnt     [N];
    logic [CW-1:0]     cnt_nxt [N];
    logic [N_PUSH-1:0] press, rel;

    assign d = s2 ^ INV;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        st_nxt = st;
        accept = '0;
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = '0;
            if (d[i] != st[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    accept[i] = 1'b1;
                    st_nxt[i] = d[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= INV;
            s2    <= INV;
            st    <= '0;
            press <= '0;
            rel   <= '0;
            // NOTE: the counter array is ordinary flops, not RAM, so it is reset like any register.
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            s1    <= {io.sw_in, io.key_n_in};
            s2    <= s1;
            st    <= st_nxt;
            press <= accept[N_PUSH-1:0] & st_nxt[N_PUSH-1:0];
            rel   <= accept[N_PUSH-1:0] & ~st_nxt[N_PUSH-1:0];
            for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    assign io.push_out     = st[N_PUSH-1:0];
    assign io.sw_out       = st[N-1:N_PUSH];
    assign io.push_press   = press;
    assign io.push_release = rel;
endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner, checked against a sliding-window model:
// a level is accepted once the last DB_CYCLES synchronised samples all disagree with the held level.
module tb_input_conditioner;
    localparam int DB     = 4;
    localparam int N_PUSH = 4;
    localparam int N_SW   = 10;
    localparam int N      = N_PUSH + N_SW;
    localparam logic [N-1:0] INV = {{N_SW{1'b0}}, {N_PUSH{1'b1}}};

    logic clk = 1'b0;
    logic reset_n;
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    input_conditioner_if #(.N_PUSH(N_PUSH), .N_SW(N_SW)) bus ();

    input_conditioner #(.DB_CYCLES(DB), .N_PUSH(N_PUSH), .N_SW(N_SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: raw pins reach the debouncer two edges late; dwin holds the recent samples.
    logic [N-1:0]      raw_q [$];
    logic [N-1:0]      dwin  [$];
    logic [N-1:0]      st_m;
    logic [N_PUSH-1:0] exp_press, exp_release;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        raw_q = {};
        dwin  = {};
        raw_q.push_back(INV);
        raw_q.push_back(INV);
        st_m        = '0;
        exp_press   = '0;
        exp_release = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] d, acc;
        d = raw_q.pop_front() ^ INV;
        raw_q.push_back({bus.sw_in, bus.key_n_in});
        dwin.push_back(d);
        if (dwin.size() > DB) void'(dwin.pop_front());
        acc = '0;
        if (dwin.size() == DB) begin
            for (int ch = 0; ch < N; ch++) begin
                acc[ch] = 1'b1;
                foreach (dwin[k]) if (dwin[k][ch] == st_m[ch]) acc[ch] = 1'b0;
            end
        end
        st_m        = st_m ^ acc;
        exp_press   = acc[N_PUSH-1:0] & st_m[N_PUSH-1:0];
        exp_release = acc[N_PUSH-1:0] & ~st_m[N_PUSH-1:0];
    endtask

    task automatic compare_all();
        check("push_out",     32'(bus.push_out),     32'(st_m[N_PUSH-1:0]));
        check("sw_out",       32'(bus.sw_out),       32'(st_m[N-1:N_PUSH]));
        check("push_press",   32'(bus.push_press),   32'(exp_press));
        check("push_release", 32'(bus.push_release), 32'(exp_release));
    endtask

    // Drive pins away from the edge, let one edge pass, compare on the falling edge.
    task automatic cycle(input logic [N_PUSH-1:0] k, input logic [N_SW-1:0] s);
        bus.key_n_in = k;
        bus.sw_in    = s;
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset(input int hold, input logic [N_PUSH-1:0] k, input logic [N_SW-1:0] s);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_push_out", 32'(bus.push_out),     32'h0);
        check("rst_sw_out",   32'(bus.sw_out),       32'h0);
        check("rst_press",    32'(bus.push_press),   32'h0);
        check("rst_release",  32'(bus.push_release), 32'h0);
        for (int i = 0; i < hold; i++) cycle(k, s);
        reset_n = 1'b1;
    endtask

    initial begin
        int first, cnt;
        logic [N_PUSH-1:0] k;
        logic [N_SW-1:0]   s;

        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(4'hF, '0);
        reset_n = 1'b1;

        // Reset values: make outputs non-zero, start new counts, then reset mid-cycle.
        for (int i = 0; i < 8; i++) cycle(4'b1100, 10'h3FF);
        check("pre_rst_push", 32'(bus.push_out), 32'h3);
        for (int i = 0; i < 3; i++) cycle(4'hF, '0);
        async_reset(2, 4'hF, '0);
        for (int i = 0; i < 20; i++) cycle(4'hF, '0);
        check("idle_push_out", 32'(bus.push_out), 32'h0);
        check("idle_sw_out",   32'(bus.sw_out),   32'h0);

        // Clean press then release of key 0.
        first = -1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1110, '0);
            if (bus.push_press[0]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("press_edge",  32'(first), 32'd5);
        check("press_count", 32'(cnt),   32'd1);
        first = -1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'hF, '0);
            if (bus.push_release[0]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("release_edge",  32'(first), 32'd5);
        check("release_count", 32'(cnt),   32'd1);

        // Bounce on key 1: 3 low, 1 high, 3 low, then high.
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle((i < 3 || (i > 3 && i < 7)) ? 4'b1101 : 4'hF, '0);
            cnt += int'(bus.push_out[1]) + int'(bus.push_press[1]) + int'(bus.push_release[1]);
        end
        check("bounce_quiet", 32'(cnt), 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1101, '0);
            cnt += int'(bus.push_press[1]);
        end
        check("bounce_press_count", 32'(cnt), 32'd1);
        for (int i = 0; i < 8; i++) cycle(4'hF, '0);

        // Keys 0 and 3 plus a switch pattern land on the same edge.
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0110, 10'h2A5);
            if (i == 5) begin
                check("multi_press",  32'(bus.push_press), 32'h9);
                check("multi_sw_out", 32'(bus.sw_out),     32'h2A5);
            end
        end
        for (int i = 0; i < 8; i++) cycle(4'hF, '0);

        // Reset while key 2 is mid-count; key stays held across reset.
        for (int i = 0; i < 4; i++) cycle(4'b1011, '0);
        async_reset(3, 4'b1011, '0);
        first = -1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1011, '0);
            if (bus.push_press[2]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("rst_mid_press_edge",  32'(first), 32'd5);
        check("rst_mid_press_count", 32'(cnt),   32'd1);
        for (int i = 0; i < 8; i++) cycle(4'hF, '0);

        // Long hold on key 0.
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(4'b1110, '0);
            cnt += int'(bus.push_press[0]);
        end
        check("held_press_count", 32'(cnt), 32'd1);
        check("held_push_out0",   32'(bus.push_out[0]), 32'd1);
        for (int i = 0; i < 8; i++) cycle(4'hF, '0);

        // Random bouncing pins with occasional resets.
        k = 4'hF;
        s = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) k[$urandom_range(0, N_PUSH-1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) s[$urandom_range(0, N_SW-1)]   ^= 1'b1;
            if ($urandom_range(0, 399) == 0) async_reset($urandom_range(1, 3), k, s);
            else cycle(k, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
